fp_mant_normalizer: RTL and testbench

Sequential post-add normalizer for the floating-point adder datapath. It is the consumer and controller side of the mantissa shift path. It takes the raw adder result (carry bit, 24-bit mantissa, biased exponent) and normalizes it one bit per cycle: at most one right shift on carry-out, otherwise left shifts until the MSB is 1. The exponent is adjusted in lockstep. A start/done handshake to the adder control FSM frames each operation.

---
 rtl/fp_mant_normalizer_pkg.sv | 19 +
 rtl/fp_mant_normalizer_if.sv | 46 ++++
 rtl/fp_mant_normalizer_shift_reg.sv | 32 +++
 rtl/fp_mant_normalizer.sv | 144 ++++++++++++++
 tb/tb_fp_mant_normalizer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fp_mant_normalizer_pkg.sv
// fp_norm_pkg: shared types and constants for the post-add mantissa normalizer.
//   norm_state_e  - normalizer FSM states (IDLE, EVAL, DONE)
//   MANT_W_DEF    - default mantissa width including hidden bit
//   EXP_W_DEF     - default biased exponent width
//   EXP_ALL_ONES  - overflow/inf exponent encoding at the default width
package fp_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } norm_state_e;

    localparam int unsigned MANT_W_DEF = 24;
    localparam int unsigned EXP_W_DEF  = 8;

    localparam logic [EXP_W_DEF-1:0] EXP_ALL_ONES = '1;

endpackage

// File: rtl/fp_mant_normalizer_if.sv
// fp_mant_normalizer_if: handshake and data bundle between the adder control
// FSM (master) and the mantissa normalizer (slave).
//   start/carry_in/mant_in/exp_in      master -> slave, operation request
//   mant_out/exp_out/busy/done         slave -> master, result and status
//   overflow/underflow                 slave -> master, result flags
//   sticky (FP_NORM_STICKY_EN only)    slave -> master, bit dropped by right shift
interface fp_mant_normalizer_if #(
    parameter int unsigned MANT_W = 24,
    parameter int unsigned EXP_W  = 8
) ();

    logic              start;
    logic              carry_in;
    logic [MANT_W-1:0] mant_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              underflow;
`ifdef FP_NORM_STICKY_EN
    logic              sticky;

    modport master (
        output start, carry_in, mant_in, exp_in,
        input  mant_out, exp_out, busy, done, overflow, underflow, sticky
    );

    modport slave (
        input  start, carry_in, mant_in, exp_in,
        output mant_out, exp_out, busy, done, overflow, underflow, sticky
    );
`else
    modport master (
        output start, carry_in, mant_in, exp_in,
        input  mant_out, exp_out, busy, done, overflow, underflow
    );

    modport slave (
        input  start, carry_in, mant_in, exp_in,
        output mant_out, exp_out, busy, done, overflow, underflow
    );
`endif

endinterface

// File: rtl/fp_mant_normalizer_shift_reg.sv
// norm_shift_reg: MANT_W-wide mantissa register for the normalizer.
//   clk, rst_n  - clock, asynchronous active-low reset (clears q)
//   load        - parallel load of load_val (highest priority)
//   shift_r     - shift right one bit, ser_in enters at the MSB
//   shift_l     - shift left one bit, zero enters at the LSB
//   q           - register contents
module norm_shift_reg #(
    parameter int unsigned MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [MANT_W-1:0] load_val,
    input  logic              shift_r,
    input  logic              ser_in,
    input  logic              shift_l,
    output logic [MANT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_r) begin
            q <= {ser_in, q[MANT_W-1:1]};
        end else if (shift_l) begin
            q <= {q[MANT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/fp_mant_normalizer.sv
// fp_mant_normalizer: sequential post-add normalizer, one bit per cycle.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, aborts any operation in flight
//   bus    - fp_mant_normalizer_if.slave: start/carry_in/mant_in/exp_in in,
//            mant_out/exp_out/busy/done/overflow/underflow out
// Optional: define FP_NORM_STICKY_EN to add bus.sticky, the bit dropped by a
// carry right shift.
module fp_mant_normalizer
    import fp_norm_pkg::*;
#(
    parameter int unsigned MANT_W = MANT_W_DEF,
    parameter int unsigned EXP_W  = EXP_W_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_mant_normalizer_if.slave  bus
);

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    // Any carry-in at or above this exponent would increment into all-ones.
    localparam logic [EXP_W-1:0] EXP_OVF = EXP_MAX - EXP_ONE;

    norm_state_e       state_q, state_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [MANT_W-1:0] mant_q;
    logic              sr_load, sr_shift_r, sr_shift_l;
    logic [MANT_W-1:0] sr_load_val;
`ifdef FP_NORM_STICKY_EN
    logic              sticky_q, sticky_d;
`endif

    norm_shift_reg #(.MANT_W(MANT_W)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sr_load),
        .load_val (sr_load_val),
        .shift_r  (sr_shift_r),
        .ser_in   (1'b1),
        .shift_l  (sr_shift_l),
        .q        (mant_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef FP_NORM_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`ifdef FP_NORM_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        sr_load     = 1'b0;
        sr_load_val = '0;
        sr_shift_r  = 1'b0;
        sr_shift_l  = 1'b0;
`ifdef FP_NORM_STICKY_EN
        sticky_d    = sticky_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_load     = 1'b1;
                    sr_load_val = bus.mant_in;
                    exp_d       = bus.exp_in;
                    carry_d     = bus.carry_in;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
`ifdef FP_NORM_STICKY_EN
                    sticky_d    = 1'b0;
`endif
                    state_d     = EVAL;
                end
            end
            EVAL: begin
                if (carry_q && (exp_q >= EXP_OVF)) begin
                    sr_load = 1'b1;             // load_val default '0 clears mantissa
                    exp_d   = EXP_MAX;
                    carry_d = 1'b0;
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (carry_q) begin
                    sr_shift_r = 1'b1;
                    exp_d      = exp_q + EXP_ONE;
                    carry_d    = 1'b0;
`ifdef FP_NORM_STICKY_EN
                    sticky_d   = mant_q[0];
`endif
                end else if (mant_q == '0) begin
                    exp_d   = '0;
                    state_d = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    state_d = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    exp_d   = '0;
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    sr_shift_l = 1'b1;
                    exp_d      = exp_q - EXP_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mant_out  = mant_q;
    assign bus.exp_out   = exp_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`ifdef FP_NORM_STICKY_EN
    assign bus.sticky    = sticky_q;
`endif

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Testbench for fp_mant_normalizer: directed vector table plus hand-written
// handshake and reset sequences. Honors FP_NORM_STICKY_EN.
module tb_fp_mant_normalizer;

    localparam int unsigned MW = 24;
    localparam int unsigned EW = 8;
    localparam int unsigned BUDGET = 40;

    typedef struct {
        string          nm;
        logic           carry;
        logic [MW-1:0]  mant;
        logic [EW-1:0]  expo;
        logic [MW-1:0]  mant_e;
        logic [EW-1:0]  exp_e;
        logic           ovf_e;
        logic           unf_e;
        logic           stk_e;
        int unsigned    lat_e;   // negedges after the accept edge until done is seen (shifts + 2)
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs [9];

    fp_mant_normalizer_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    fp_mant_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic drive(input logic c, input logic [MW-1:0] m, input logic [EW-1:0] e);
        bus.carry_in = c;
        bus.mant_in  = m;
        bus.exp_in   = e;
    endtask

    // Issue a start, then count negedges until done; busy must stay high meanwhile.
    task automatic run_op(input logic c, input logic [MW-1:0] m, input logic [EW-1:0] e,
                          output int unsigned cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        drive(c, m, e);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int unsigned i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic chk_result(input string nm, input vec_t v);
        chk({nm, ".mant"}, 32'(bus.mant_out), 32'(v.mant_e));
        chk({nm, ".exp"},  32'(bus.exp_out),  32'(v.exp_e));
        chk({nm, ".ovf"},  32'(bus.overflow), 32'(v.ovf_e));
        chk({nm, ".unf"},  32'(bus.underflow), 32'(v.unf_e));
`ifdef FP_NORM_STICKY_EN
        chk({nm, ".sticky"}, 32'(bus.sticky), 32'(v.stk_e));
`endif
    endtask

    initial begin
        int unsigned cyc;
        bit          busy_ok;
        bit          saw_done;

        //        name      c  mant_in       exp   mant_out      exp  ovf unf stk lat
        vecs[0] = '{"norm",  0, 24'h800000, 8'd127, 24'h800000, 8'd127, 0, 0, 0, 2};
        vecs[1] = '{"worst", 0, 24'h000001, 8'd127, 24'h800000, 8'd104, 0, 0, 0, 25};
        vecs[2] = '{"carry", 1, 24'h000001, 8'd100, 24'h800000, 8'd101, 0, 0, 1, 3};
        vecs[3] = '{"ovf",   1, 24'hFFFFFF, 8'd254, 24'h000000, 8'd255, 1, 0, 0, 2};
        vecs[4] = '{"unf",   0, 24'h000010, 8'd3,   24'h000040, 8'd0,   0, 1, 0, 4};
        vecs[5] = '{"zero",  0, 24'h000000, 8'd50,  24'h000000, 8'd0,   0, 0, 0, 2};
        vecs[6] = '{"c253",  1, 24'h000003, 8'd253, 24'h800001, 8'd254, 0, 0, 1, 3};
        vecs[7] = '{"e2",    0, 24'h400000, 8'd2,   24'h800000, 8'd1,   0, 0, 0, 3};
        vecs[8] = '{"e1",    0, 24'h400000, 8'd1,   24'h400000, 8'd0,   0, 1, 0, 2};

        bus.start = 1'b0;
        drive(1'b0, '0, '0);

        // Reset state
        #12;
        chk("rst.mant", 32'(bus.mant_out), 0);
        chk("rst.exp",  32'(bus.exp_out), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.flags", {30'd0, bus.overflow, bus.underflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].carry, vecs[i].mant, vecs[i].expo, cyc, busy_ok);
            chk({vecs[i].nm, ".lat"},  cyc, vecs[i].lat_e);
            chk({vecs[i].nm, ".busy"}, 32'(busy_ok), 1);
            chk_result(vecs[i].nm, vecs[i]);
            @(negedge clk);
            chk({vecs[i].nm, ".pulse"}, 32'(bus.done), 0);
            chk({vecs[i].nm, ".hold"},  32'(bus.mant_out), 32'(vecs[i].mant_e));
        end

        // start during EVAL is ignored: 0x000100 @127 needs 15 shifts
        @(negedge clk);
        drive(1'b0, 24'h000100, 8'd127);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        drive(1'b1, 24'h800000, 8'd5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done = 1'b0;
        for (int unsigned i = 0; i < BUDGET; i++) begin
            if (bus.done) begin
                saw_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ign.done", 32'(saw_done), 1);
        chk("ign.mant", 32'(bus.mant_out), 32'h800000);
        chk("ign.exp",  32'(bus.exp_out), 127 - 15);
        // start in the DONE cycle is ignored as well
        drive(1'b0, 24'h000001, 8'd9);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("dstart.busy", 32'(bus.busy), 0);
        chk("dstart.exp",  32'(bus.exp_out), 127 - 15);
        @(negedge clk);
        chk("dstart.idle", 32'(bus.busy), 0);

        // Asynchronous reset mid-shift
        @(negedge clk);
        drive(1'b0, 24'h000001, 8'd127);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.mant", 32'(bus.mant_out), 0);
        chk("arst.exp",  32'(bus.exp_out), 0);
        chk("arst.busy", 32'(bus.busy), 0);
        chk("arst.done", 32'(bus.done), 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("arst.nodone", 32'(saw_done), 0);

        // Normal operation after reset release
        run_op(vecs[2].carry, vecs[2].mant, vecs[2].expo, cyc, busy_ok);
        chk("post.lat", cyc, vecs[2].lat_e);
        chk_result("post", vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
